ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Read-side counterpart of the MAC result write-back path. On a start pulse it
//  fetches LANES consecutive words from the sync-read data RAM at base_addr.
//  It presents them in parallel as OP1..OP4 (18-bit) to the MAC units and
//  pulses op_valid once all four are loaded. It sits between the data RAM
//  read port and the MAC operand inputs.
// PARAMETERS
//  DATA_W   18  operand width; taken from dataRAM[DATA_W-1:0]
//  ADDR_W   8   RAM address width
//  LANES    4   words per fetch; fixed at 4 (one per OPn port)
//  RAM_LAT  1   RAM read latency in cycles, address to dataRAM; legal 1..3
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  start      in   1       fetch request; sampled only in IDLE
//  base_addr  in   ADDR_W  first word address; latched when start is accepted
//  dataRAM    in   32      RAM read data; bits [31:DATA_W] ignored
//  ram_en     out  1       RAM read enable
//  address    out  ADDR_W  RAM read address
//  busy       out  1       high from accept through the last WAIT cycle
//  OP1..OP4   out  DATA_W  operands; word base+0 -> OP1 ... base+3 -> OP4
//  op_valid   out  1       1-cycle pulse: OP1..OP4 newly updated
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; ram_en=0, address=0, busy=0, op_valid=0,
//   OP1..OP4=0, and the staging regs, index, latched base and capture pipe
//   all cleared. Release is synchronous to the next clk edge.
//  FSM states: IDLE, READ, WAIT.
//   IDLE: start=1 at an edge -> latch base_addr, idx=0, go READ.
//   READ: ram_en=1, address=base+idx (mod 2^ADDR_W), idx++ each cycle;
//     after idx=3 -> WAIT.
//   WAIT: ram_en=0; stays RAM_LAT cycles, then -> IDLE.
//  Outputs: ram_en, address and busy are registered (decoded from state
//   regs, no comb path from start). address holds its last value when ram_en=0.
//  Capture: a valid/index tag pipeline of depth RAM_LAT tracks each issued
//   address. dataRAM[DATA_W-1:0] is written to stage[tag_idx] when the tag
//   emerges.
//  Commit: at the edge that captures word 3, stage[0..2] and the incoming
//   word 3 load into OP1..OP4 together, and op_valid is set for exactly one
//   cycle. OP1..OP4 never show a partially loaded set and hold until the
//   next commit.
//  Timing for RAM_LAT=1, start high in cycle 0:
//   ram_en=1 in cycles 1-4 with address base..base+3; WAIT is cycle 5;
//   op_valid=1 and OPs valid in cycle 6; busy=1 in cycles 1-5.
//   Total latency from start to op_valid is 5+RAM_LAT cycles.
//  Boundaries:
//   - start while busy=1: ignored, not queued.
//   - start in the op_valid cycle: accepted (state is IDLE), so back-to-back
//     fetches have a period of 5+RAM_LAT cycles.
//   - address wrap: base=0xFE reads FE, FF, 00, 01.
//   - rst low mid-fetch: abort; no commit, op_valid stays 0, OPs go to 0.
//   - no arithmetic on data; upper dataRAM bits are dropped, not checked.
// TESTING
//  1 RAM[0x10..0x13]=0x00001,0x3FFFF,0x12345,0x20000; start, base=0x10 ->
//    addr 10,11,12,13 in cycles 1-4; op_valid in cycle 6;
//    OP1..OP4 = 0x00001,0x3FFFF,0x12345,0x20000.
//  2 base=0xFE, RAM[FE,FF,00,01]=1,2,3,4 -> address sequence FE,FF,00,01;
//    OP1..OP4 = 1,2,3,4.
//  3 start re-pulsed in cycles 2 and 5 -> ignored: exactly one op_valid,
//    in cycle 6; ram_en high for 4 cycles only.
//  4 start held high continuously -> op_valid every 6 cycles; OPs change
//    only on op_valid cycles.
//  5 rst=0 in cycle 3 -> all outputs 0 immediately and no op_valid; after
//    release a new start completes normally with the expected data.
//  6 RAM words 0xFFFC0005 and RAM_LAT=2 -> OP = 0x00005 (upper bits
//    dropped); op_valid in cycle 7.

Source files
------------

// File: rtl/ram_loader_if.sv
// Operand-fetch bus between ram_loader, the data RAM read port and the MAC operand inputs.
// master = loader side; slave = RAM/MAC side.
interface ram_loader_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       dataRAM;
    logic              ram_en;
    logic [ADDR_W-1:0] address;
    logic              busy;
    logic [DATA_W-1:0] OP1;
    logic [DATA_W-1:0] OP2;
    logic [DATA_W-1:0] OP3;
    logic [DATA_W-1:0] OP4;
    logic              op_valid;

    modport master (
        input  start, base_addr, dataRAM,
        output ram_en, address, busy, OP1, OP2, OP3, OP4, op_valid
    );

    modport slave (
        output start, base_addr, dataRAM,
        input  ram_en, address, busy, OP1, OP2, OP3, OP4, op_valid
    );
endinterface

// File: rtl/ram_loader.sv
// Fetches LANES consecutive words from a sync-read RAM and presents them together
// as MAC operands, pulsing op_valid once the full set is committed.
module ram_loader #(
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram_loader_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(LANES);
    localparam int unsigned CNT_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RAM_LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] address_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  wait_q;
    logic              ram_en_q;
    logic              busy_q;
    logic              op_valid_q;
    logic [DATA_W-1:0] stage_q  [LANES-1];
    logic [DATA_W-1:0] op_q     [LANES];
    logic              tag_vld_q [RAM_LAT];
    logic [IDX_W-1:0]  tag_idx_q [RAM_LAT];

    logic [DATA_W-1:0] word_c;
    logic              unused_hi;

    assign word_c    = bus.dataRAM[DATA_W-1:0];
    assign unused_hi = ^bus.dataRAM[31:DATA_W];

    // Sequencer, tag pipe tracking in-flight reads, staging and commit of the operand set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            address_q  <= '0;
            idx_q      <= '0;
            wait_q     <= '0;
            ram_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            op_valid_q <= 1'b0;
            for (int unsigned k = 0; k < LANES - 1; k++) stage_q[k] <= '0;
            for (int unsigned k = 0; k < LANES; k++)     op_q[k]    <= '0;
            for (int unsigned i = 0; i < RAM_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            op_valid_q   <= 1'b0;
            tag_vld_q[0] <= ram_en_q;
            tag_idx_q[0] <= idx_q;
            for (int unsigned i = 1; i < RAM_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            // Tag emerges alongside its data word; the last word commits the whole set.
            if (tag_vld_q[RAM_LAT-1]) begin
                if (tag_idx_q[RAM_LAT-1] == LAST_IDX) begin
                    for (int unsigned k = 0; k < LANES - 1; k++) op_q[k] <= stage_q[k];
                    op_q[LANES-1] <= word_c;
                    op_valid_q    <= 1'b1;
                end else begin
                    for (int unsigned k = 0; k < LANES - 1; k++) begin
                        if (tag_idx_q[RAM_LAT-1] == IDX_W'(k)) stage_q[k] <= word_c;
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        base_q    <= bus.base_addr;
                        address_q <= bus.base_addr;
                        idx_q     <= '0;
                        ram_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    if (idx_q == LAST_IDX) begin
                        ram_en_q <= 1'b0;
                        wait_q   <= '0;
                        state_q  <= WAIT;
                    end else begin
                        idx_q     <= idx_q + IDX_W'(1);
                        address_q <= base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                    end
                end
                WAIT: begin
                    if (wait_q == LAST_WAIT) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_en   = ram_en_q;
    assign bus.address  = address_q;
    assign bus.busy     = busy_q;
    assign bus.op_valid = op_valid_q;
    assign bus.OP1      = op_q[0];
    assign bus.OP2      = op_q[1];
    assign bus.OP3      = op_q[2];
    assign bus.OP4      = op_q[3];
endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (RAM_LAT 1 and 2) share stimulus; a cycle-indexed
// reference model plus an operand scoreboard checks bus timing and committed data.
module tb_ram_loader;
    localparam int unsigned DW   = 18;
    localparam int unsigned AW   = 8;
    localparam int unsigned MAXC = 4096;

    typedef struct packed {
        logic [3:0][17:0] op;
        int               due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start;
    logic [7:0] base;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_loader_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
    ram_loader_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

    ram_loader #(.DATA_W(DW), .ADDR_W(AW), .LANES(4), .RAM_LAT(1))
        dut0 (.clk(clk), .rst(rst), .bus(b0.master));
    ram_loader #(.DATA_W(DW), .ADDR_W(AW), .LANES(4), .RAM_LAT(2))
        dut1 (.clk(clk), .rst(rst), .bus(b1.master));

    assign b0.start     = start;
    assign b1.start     = start;
    assign b0.base_addr = base;
    assign b1.base_addr = base;

    // RAM behaviour: latency 1 for dut0, 2 for dut1; junk on the bus when not enabled.
    logic [31:0] mem [256];
    logic [31:0] p1;
    always @(posedge clk) begin
        b0.dataRAM <= b0.ram_en ? mem[b0.address] : $urandom;
        p1         <= b1.ram_en ? mem[b1.address] : $urandom;
        b1.dataRAM <= p1;
    end

    bit               exp_en   [2][MAXC];
    logic [7:0]       exp_addr [2][MAXC];
    bit               exp_busy [2][MAXC];
    bit               exp_vld  [2][MAXC];
    exp_t             sbq      [2][$];
    logic [3:0][17:0] cur_ops  [2];
    int               free_c   [2];
    int               vectors = 0;
    int               miscompares = 0;

    function automatic void chk(string nm, logic [95:0] act, logic [95:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endfunction

    // Reference: a fetch accepted in cycle t reads base+k in t+1+k, stays busy to t+4+L,
    // and delivers the four low-18-bit words in t+5+L.
    task automatic accept(input int d, input int t, input logic [7:0] bb);
        exp_t e;
        int   lat = d + 1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] a = bb + 8'(k);
            exp_en[d][t+1+k]   = 1'b1;
            exp_addr[d][t+1+k] = a;
            e.op[k]            = mem[a][17:0];
        end
        for (int c = t + 1; c <= t + 4 + lat; c++) exp_busy[d][c] = 1'b1;
        exp_vld[d][t+5+lat] = 1'b1;
        e.due     = t + 5 + lat;
        sbq[d].push_back(e);
        free_c[d] = t + 5 + lat;
    endtask

    task automatic mon(input int d, input logic en, input logic [7:0] ad, input logic bz,
                       input logic vl, input logic [3:0][17:0] ops);
        exp_t e;
        chk($sformatf("ram_en[%0d]", d), 96'(en), 96'(exp_en[d][cyc]));
        chk($sformatf("busy[%0d]", d), 96'(bz), 96'(exp_busy[d][cyc]));
        chk($sformatf("op_valid[%0d]", d), 96'(vl), 96'(exp_vld[d][cyc]));
        if (exp_en[d][cyc]) chk($sformatf("address[%0d]", d), 96'(ad), 96'(exp_addr[d][cyc]));
        if (vl === 1'b1) begin
            if (sbq[d].size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL op_valid[%0d] cycle %0d: got pulse, expected no pending fetch", d, cyc);
            end else begin
                e = sbq[d].pop_front();
                chk($sformatf("op_due[%0d]", d), 96'(cyc), 96'(e.due));
                cur_ops[d] = e.op;
            end
        end
        chk($sformatf("ops[%0d]", d), 96'(ops), 96'(cur_ops[d]));
    endtask

    always @(negedge clk) begin
        mon(0, b0.ram_en, b0.address, b0.busy, b0.op_valid, {b0.OP4, b0.OP3, b0.OP2, b0.OP1});
        mon(1, b1.ram_en, b1.address, b1.busy, b1.op_valid, {b1.OP4, b1.OP3, b1.OP2, b1.OP1});
    end

    task automatic check_zero();
        chk("rst ram_en[0]", 96'(b0.ram_en), 96'(0));
        chk("rst busy[0]", 96'(b0.busy), 96'(0));
        chk("rst op_valid[0]", 96'(b0.op_valid), 96'(0));
        chk("rst address[0]", 96'(b0.address), 96'(0));
        chk("rst ops[0]", 96'({b0.OP4, b0.OP3, b0.OP2, b0.OP1}), 96'(0));
        chk("rst ram_en[1]", 96'(b1.ram_en), 96'(0));
        chk("rst busy[1]", 96'(b1.busy), 96'(0));
        chk("rst op_valid[1]", 96'(b1.op_valid), 96'(0));
        chk("rst address[1]", 96'(b1.address), 96'(0));
        chk("rst ops[1]", 96'({b1.OP4, b1.OP3, b1.OP2, b1.OP1}), 96'(0));
    endtask

    task automatic step(input bit s, input logic [7:0] bb);
        @(negedge clk);
        start = s;
        base  = bb;
        if (s && rst) begin
            for (int d = 0; d < 2; d++) if (cyc >= free_c[d]) accept(d, cyc, bb);
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int c = cyc; c < cyc + 12; c++) begin
                exp_en[d][c]   = 1'b0;
                exp_busy[d][c] = 1'b0;
                exp_vld[d][c]  = 1'b0;
            end
            sbq[d].delete();
            cur_ops[d] = '0;
            free_c[d]  = 0;
        end
        #1;
        check_zero();
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    initial begin
        start      = 1'b0;
        base       = 8'h00;
        cur_ops[0] = '0;
        cur_ops[1] = '0;
        free_c[0]  = 0;
        free_c[1]  = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #1 rst = 1'b0;
        #1 check_zero();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        mem[8'h10] = 32'h00001; mem[8'h11] = 32'h3FFFF;
        mem[8'h12] = 32'h12345; mem[8'h13] = 32'h20000;
        step(1'b1, 8'h10);
        idle(10);

        mem[8'hFE] = 32'd1; mem[8'hFF] = 32'd2; mem[8'h00] = 32'd3; mem[8'h01] = 32'd4;
        step(1'b1, 8'hFE);
        idle(10);

        step(1'b1, 8'h30); step(1'b0, 8'h00); step(1'b1, 8'h40);
        step(1'b0, 8'h00); step(1'b0, 8'h00); step(1'b1, 8'h50);
        idle(10);

        repeat (30) step(1'b1, 8'($urandom));
        idle(10);

        step(1'b1, 8'h60); step(1'b0, 8'h00); step(1'b0, 8'h00);
        do_reset(2);
        step(1'b1, 8'h61);
        idle(10);

        mem[8'h70] = 32'hFFFC0005; mem[8'h71] = 32'hFFFFFFFF;
        mem[8'h72] = 32'h8003FFFE; mem[8'h73] = 32'h00040000;
        step(1'b1, 8'h70);
        idle(10);

        repeat (1500) begin
            if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
            else step($urandom_range(0, 2) == 0, 8'($urandom));
        end
        idle(12);

        chk("scoreboard drained[0]", 96'(sbq[0].size()), 96'(0));
        chk("scoreboard drained[1]", 96'(sbq[1].size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
